// File: rtl/cipher_cfg_sequencer_if.sv
// cipher_cfg_sequencer_if: host-side and cipher-core-side signals of the configuration sequencer
interface cipher_cfg_sequencer_if #(parameter int M = 32);
   localparam int CFG_W = 4*M+3;
   logic start, verify_en, run_tx, run_rx, stop;
   logic [CFG_W-1:0] cfg_word, readback;
   logic [15:0] run_len;
   logic core_cfg_o, core_cfg_en, core_cfg_i, core_tx_en, core_rx_en;
   logic busy, done, verify_err;
   modport master (
      output start, verify_en, cfg_word, run_len, run_tx, run_rx, stop, core_cfg_o,
      input core_cfg_en, core_cfg_i, core_tx_en, core_rx_en, busy, done, verify_err, readback
   );
   modport slave (
      input start, verify_en, cfg_word, run_len, run_tx, run_rx, stop, core_cfg_o,
      output core_cfg_en, core_cfg_i, core_tx_en, core_rx_en, busy, done, verify_err, readback
   );
endinterface

// File: rtl/cipher_cfg_sequencer.sv
// cipher_cfg_sequencer: loads/verifies the cipher core config chain, then gates a keystream burst
module cipher_cfg_sequencer #(parameter int M = 32) (
   input logic clk,
   input logic rst_n,
   cipher_cfg_sequencer_if.slave bus
);
   localparam int CFG_W = 4*M+3;
   localparam int IW = $clog2(CFG_W);
   localparam logic [15:0] LAST = 16'(CFG_W-1);
   typedef enum logic [2:0] {IDLE, LOAD, VERIFY, SETTLE, RUN} state_t;
   state_t state, nxt;
   logic [CFG_W-1:0] shadow, readback;
   logic [15:0] bit_cnt, run_cnt, run_len_q;
   logic verify_q, err_q, done_q, tx_q, rx_q;
   logic shifting, last_bit, cur_bit, mism, run_last;
   assign shifting = state == LOAD || state == VERIFY;
   assign last_bit = bit_cnt == LAST;
   assign cur_bit = shadow[bit_cnt[IW-1:0]];
   assign mism = state == VERIFY && bus.core_cfg_o != cur_bit;
   assign run_last = run_len_q != 16'd0 && run_cnt == 16'd1;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= nxt;
   // stop wins over everything; in IDLE it also masks start
   always_comb begin
      nxt = state;
      if (bus.stop) nxt = IDLE;
      else
         case (state)
            IDLE: nxt = bus.start ? LOAD : IDLE;
            LOAD: nxt = last_bit ? (verify_q ? VERIFY : SETTLE) : LOAD;
            VERIFY: nxt = last_bit ? ((err_q || mism) ? IDLE : SETTLE) : VERIFY;
            SETTLE: nxt = RUN;
            RUN: nxt = run_last ? IDLE : RUN;
            default: nxt = IDLE;
         endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         shadow <= '0;
         readback <= '0;
         bit_cnt <= '0;
         run_cnt <= '0;
         run_len_q <= '0;
         verify_q <= 1'b0;
         err_q <= 1'b0;
         done_q <= 1'b0;
         tx_q <= 1'b0;
         rx_q <= 1'b0;
      end else begin
         done_q <= !bus.stop && ((state == RUN && run_last) || (state == VERIFY && last_bit && (err_q || mism)));
         tx_q <= nxt == RUN && bus.run_tx;
         rx_q <= nxt == RUN && bus.run_rx;
         if (state == IDLE && bus.start && !bus.stop) begin
            shadow <= bus.cfg_word;
            verify_q <= bus.verify_en;
            run_len_q <= bus.run_len;
            err_q <= 1'b0;
            bit_cnt <= '0;
         end
         if (shifting) bit_cnt <= last_bit ? '0 : bit_cnt + 16'd1;
         if (state == LOAD) readback <= {bus.core_cfg_o, readback[CFG_W-1:1]};
         if (mism) err_q <= 1'b1;
         if (state == SETTLE) run_cnt <= run_len_q;
         else if (state == RUN && run_len_q != 16'd0) run_cnt <= run_cnt - 16'd1;
      end
   assign bus.core_cfg_en = shifting;
   assign bus.core_cfg_i = shifting && cur_bit;
   assign bus.core_tx_en = tx_q;
   assign bus.core_rx_en = rx_q;
   assign bus.busy = state != IDLE;
   assign bus.done = done_q;
   assign bus.verify_err = err_q;
   assign bus.readback = readback;
endmodule

// File: tb/tb_cipher_cfg_sequencer.sv
// tb_cipher_cfg_sequencer: randomized transactions against a timeline model of the sequencer
module tb_cipher_cfg_sequencer;
   localparam int M = 4;
   localparam int W = 4*M+3;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic flip = 1'b0;
   logic [W-1:0] chain = 19'h3C1E7;
   logic [W-1:0] rb_model = '0;
   int checks = 0;
   int errors = 0;
   cipher_cfg_sequencer_if #(.M(M)) bus();
   cipher_cfg_sequencer #(.M(M)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   // behavioural cipher core config chain: shifts toward bit 0 while cfg_en
   always @(posedge clk) if (bus.core_cfg_en) chain <= {bus.core_cfg_i, chain[W-1:1]};
   assign bus.core_cfg_o = chain[0] ^ flip;
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic txn(input logic [W-1:0] word, input bit v, input int len, input bit corrupt, input bit restart);
      logic [W-1:0] prev, s1, s2;
      int nshift, total, n_en, en_bad, n_busy, n_done, tx_bad, rx_bad, n_ovl;
      bit tx_prev, rx_prev, exp_run, done_last;
      prev = chain;
      s1 = '0;
      s2 = '0;
      nshift = v ? 2*W : W;
      total = corrupt ? 2*W : nshift + 1 + len;
      {n_en, en_bad, n_busy, n_done, tx_bad, rx_bad, n_ovl} = '0;
      tx_prev = 1'b0;
      rx_prev = 1'b0;
      done_last = 1'b0;
      bus.run_tx = 1'b0;
      bus.run_rx = 1'b0;
      bus.cfg_word = word;
      bus.verify_en = v;
      bus.run_len = 16'(len);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      for (int t = 0; t <= total; t++) begin
         if (t > 0) @(negedge clk);
         exp_run = !corrupt && t > nshift && t <= nshift + len;
         if (bus.core_cfg_en) begin
            if (n_en < W) s1[n_en] = bus.core_cfg_i;
            else if (n_en < 2*W) s2[n_en-W] = bus.core_cfg_i;
            n_en++;
         end
         en_bad += int'(bus.core_cfg_en != (t < nshift));
         n_busy += int'(bus.busy);
         n_done += int'(bus.done);
         if (t == total) done_last = bus.done;
         tx_bad += int'(bus.core_tx_en != (exp_run && tx_prev));
         rx_bad += int'(bus.core_rx_en != (exp_run && rx_prev));
         n_ovl += int'(bus.core_cfg_en && (bus.core_tx_en || bus.core_rx_en));
         tx_prev = 1'($urandom_range(0, 1));
         rx_prev = 1'($urandom_range(0, 1));
         bus.run_tx = tx_prev;
         bus.run_rx = rx_prev;
         flip = corrupt && t == W + 3;
         if (restart && t == 3) begin
            bus.start = 1'b1;
            bus.cfg_word = ~word;
            bus.verify_en = !v;
            bus.run_len = 16'(len + 5);
         end else bus.start = 1'b0;
      end
      flip = 1'b0;
      bus.run_tx = 1'b0;
      bus.run_rx = 1'b0;
      chk("cfg_en_cycles", 64'(n_en), 64'(nshift));
      chk("cfg_en_timing", 64'(en_bad), 0);
      chk("cfg_pass1", 64'(s1), 64'(word));
      if (v) chk("cfg_pass2", 64'(s2), 64'(word));
      chk("busy_cycles", 64'(n_busy), 64'(total));
      chk("done_count", 64'(n_done), 1);
      chk("done_at_end", 64'(done_last), 1);
      chk("tx_en_bad", 64'(tx_bad), 0);
      chk("rx_en_bad", 64'(rx_bad), 0);
      chk("cfg_run_overlap", 64'(n_ovl), 0);
      chk("readback", 64'(bus.readback), 64'(prev));
      chk("verify_err", 64'(bus.verify_err), 64'(corrupt));
      chk("core_chain", 64'(chain), 64'(word));
      rb_model = prev;
   endtask
   task automatic stop_mid_load(input logic [W-1:0] word);
      logic [W-1:0] prev, exp_rb, exp_chain;
      prev = chain;
      exp_rb = (rb_model >> 8) | (W'(prev[7:0]) << (W - 8));
      exp_chain = (prev >> 8) | (W'(word[7:0]) << (W - 8));
      bus.cfg_word = word;
      bus.verify_en = 1'b1;
      bus.run_len = 16'd4;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (7) @(negedge clk);
      bus.stop = 1'b1;
      @(negedge clk);
      bus.stop = 1'b0;
      chk("stop_outs", 64'({bus.core_cfg_en, bus.core_tx_en, bus.core_rx_en, bus.busy, bus.done}), 0);
      chk("stop_readback", 64'(bus.readback), 64'(exp_rb));
      chk("stop_chain", 64'(chain), 64'(exp_chain));
      rb_model = exp_rb;
   endtask
   task automatic run_unlimited(input logic [W-1:0] word);
      logic [W-1:0] prev;
      int bad;
      prev = chain;
      bad = 0;
      bus.run_tx = 1'b1;
      bus.run_rx = 1'b0;
      bus.cfg_word = word;
      bus.verify_en = 1'b0;
      bus.run_len = 16'd0;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (W + 1) @(negedge clk);
      for (int i = 0; i < 120; i++) begin
         if (i > 0) @(negedge clk);
         bad += int'(!bus.core_tx_en || bus.core_rx_en || bus.core_cfg_en || bus.done || !bus.busy);
      end
      chk("run0_hold", 64'(bad), 0);
      chk("run0_chain", 64'(chain), 64'(word));
      chk("run0_readback", 64'(bus.readback), 64'(prev));
      bus.stop = 1'b1;
      @(negedge clk);
      bus.stop = 1'b0;
      bus.run_tx = 1'b0;
      chk("run0_stop", 64'({bus.core_cfg_en, bus.core_cfg_i, bus.core_tx_en, bus.core_rx_en, bus.done, bus.busy}), 0);
      rb_model = prev;
   endtask
   task automatic async_reset_in_run(input logic [W-1:0] word);
      bus.run_tx = 1'b1;
      bus.run_rx = 1'b1;
      bus.cfg_word = word;
      bus.verify_en = 1'b1;
      bus.run_len = 16'd0;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (2*W + 4) @(negedge clk);
      chk("pre_rst_run", 64'({bus.busy, bus.core_tx_en, bus.core_rx_en}), 64'h7);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_outs", 64'({bus.core_cfg_en, bus.core_cfg_i, bus.core_tx_en, bus.core_rx_en, bus.busy, bus.done, bus.verify_err}), 0);
      chk("async_rst_readback", 64'(bus.readback), 0);
      @(negedge clk);
      rst_n = 1'b1;
      bus.run_tx = 1'b0;
      bus.run_rx = 1'b0;
      @(negedge clk);
      chk("post_rst_idle", 64'({bus.busy, bus.core_cfg_en, bus.core_tx_en}), 0);
      rb_model = '0;
   endtask
   initial begin
      #500000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end
   initial begin
      logic [W-1:0] w;
      bit v;
      {bus.start, bus.verify_en, bus.run_tx, bus.run_rx, bus.stop} = '0;
      bus.cfg_word = '0;
      bus.run_len = '0;
      repeat (2) @(negedge clk);
      chk("reset_outs", 64'({bus.core_cfg_en, bus.core_cfg_i, bus.core_tx_en, bus.core_rx_en, bus.busy, bus.done, bus.verify_err}), 0);
      chk("reset_readback", 64'(bus.readback), 0);
      rst_n = 1'b1;
      @(negedge clk);
      txn(19'h5A5A5, 1'b0, 8, 1'b0, 1'b0);
      txn(19'h5A5A5, 1'b1, 8, 1'b0, 1'b0);
      txn(W'($urandom), 1'b1, 6, 1'b1, 1'b0);
      bus.cfg_word = W'($urandom);
      bus.start = 1'b1;
      bus.stop = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      bus.stop = 1'b0;
      chk("start_with_stop", 64'({bus.busy, bus.core_cfg_en}), 0);
      stop_mid_load(W'($urandom));
      txn(W'($urandom), 1'b0, 5, 1'b0, 1'b1);
      for (int i = 0; i < 12; i++) begin
         w = W'($urandom);
         v = 1'($urandom_range(0, 1));
         txn(w, v, int'($urandom_range(1, 20)), v && $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
      end
      run_unlimited(W'($urandom));
      async_reset_in_run(W'($urandom));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/cipher_cfg_sequencer.md
Name: cipher_cfg_sequencer

Overview:
Controller that sequences one dual XOR stream cipher core. It serially loads the core's configuration chain of 4*M+3 bits over cfg_en/cfg_i, and captures the previous chain contents from cfg_o. It optionally re-shifts the word to verify it, then gates the core's tx_en/rx_en for an optional fixed-length burst. It sits between a host/register interface and the cipher core, and is the only driver of the core's cfg_en, cfg_i, tx_en and rx_en.

Parameters:
M, 32, cipher LFSR width; configuration chain length CFG_W = 4*M+3 (derived localparam).

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous, active-low reset
start  input  1  one-cycle pulse; begin load sequence (ignored unless state IDLE)
verify_en  input  1  sampled with start; 1 = perform VERIFY pass after LOAD
cfg_word  input  CFG_W  configuration to load; bit 0 shifted first; sampled into shadow register on accepted start
run_len  input  16  keystream burst length in cycles, sampled on accepted start; 0 = unlimited
run_tx  input  1  request tx LFSR advance while RUN
run_rx  input  1  request rx LFSR advance while RUN
stop  input  1  level; abort any state and return to IDLE next cycle
core_cfg_o  input  1  from core cfg_o (core chain bit 0 while cfg_en=1)
core_cfg_en  output  1  to core cfg_en
core_cfg_i  output  1  to core cfg_i
core_tx_en  output  1  to core tx_en
core_rx_en  output  1  to core rx_en
busy  output  1  1 in any state except IDLE
done  output  1  one-cycle pulse on RUN exit via run_len expiry, or on VERIFY completion with mismatch
verify_err  output  1  sticky mismatch flag; cleared on accepted start
readback  output  CFG_W  previous core chain contents captured during LOAD

Behaviour:
- Reset (rst_n low, async): state IDLE; all outputs 0; readback 0; shadow, bit counter and run counter 0.
- States: IDLE, LOAD, VERIFY, SETTLE, RUN. All outputs are registered and decoded from state and the shadow register.
- IDLE: start=1 and stop=0 -> latch cfg_word into shadow, verify_en and run_len; clear verify_err and bit counter; next state LOAD.
- LOAD: core_cfg_en=1; core_cfg_i=shadow[bit_cnt]. Each cycle:
  - readback <= {core_cfg_o, readback[CFG_W-1:1]};
  - bit_cnt increments.
  - After exactly CFG_W cycles with cfg_en high: bit_cnt reset to 0; next state VERIFY if verify_en, else SETTLE.
- VERIFY: re-shift the same shadow bits for CFG_W cycles, with core_cfg_en=1 and core_cfg_i=shadow[bit_cnt]. This leaves the core chain unchanged. Each cycle, compare core_cfg_o against shadow[bit_cnt]; any mismatch sets verify_err.
  - At end: mismatch -> pulse done, go to IDLE (the RUN phase is skipped).
  - No mismatch -> SETTLE.
- SETTLE: exactly one cycle with core_cfg_en=0, tx/rx disabled. This lets the core's internal ld pulse take effect. Then go to RUN, with run counter loaded from run_len.
- RUN: core_tx_en=run_tx, core_rx_en=run_rx (registered, one-cycle latency from input). core_cfg_en=0.
  - If run_len != 0: counter decrements every RUN cycle regardless of run_tx/run_rx. At count 1 -> pulse done, go to IDLE. The burst is therefore exactly run_len RUN cycles.
  - If run_len == 0: stay in RUN until stop.
- stop: highest priority in any non-IDLE state. Next cycle: IDLE, all core_* outputs 0, no done pulse.
  - stop mid-LOAD/VERIFY leaves the core chain partially shifted; readback holds the partial capture.
  - stop and start together in IDLE: start is ignored.
- start while busy: ignored; shadow, run_len and verify_en are unchanged.
- core_cfg_en and (core_tx_en|core_rx_en) are never both 1 in the same cycle.
- Counters are 16 bits wide; bit_cnt compares against CFG_W-1, which requires M <= 16383.

Test Plan:
- M=4 (CFG_W=19), core reset holds chain X; start with cfg_word=19'h5A5A5, verify_en=0, run_len=8 -> core_cfg_en high exactly 19 cycles, bits LSB-first; readback=X; SETTLE 1 cycle; core_tx_en follows run_tx for 8 cycles; done pulses once; busy falls with done.
- Same with verify_en=1 and a good core -> core_cfg_en high 38 consecutive cycles; verify_err=0; core chain still equals 19'h5A5A5 after sequence; RUN entered.
- verify_en=1, bench model corrupts one cfg_o bit on the second pass -> verify_err=1, done pulses, no core_tx_en/core_rx_en assertion, state IDLE.
- run_len=0, run_tx=1, run_rx=0 -> core_tx_en stays 1 and core_rx_en stays 0 for 100+ cycles; stop -> all core_* outputs 0 the next cycle, no done pulse.
- stop asserted at LOAD cycle 7 -> IDLE next cycle, core_cfg_en low; a second start during LOAD is ignored (shadow unchanged, checked by continuing the original load).
- rst_n dropped mid-RUN asynchronously -> all outputs 0 immediately, before the next clock edge; after release, state IDLE and busy=0.
